// File: rtl/ranked_time_pkg.sv
// Shared definitions for the ranked time board: FSM states, mode codes
// and list indices.
package ranked_time_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Offer modes: fast lists rank smaller times first, slow lists larger.
    localparam logic [1:0] MODE_FAST = 2'b10;
    localparam logic [1:0] MODE_SLOW = 2'b01;

    // Storage index of each list.
    localparam logic LIST_FAST = 1'b0;
    localparam logic LIST_SLOW = 1'b1;

endpackage

// File: rtl/ranked_time_board_rank_locator.sv
// rank_locator: finds where a new time belongs in one sorted list.
// Ties fall after existing equal entries because only a strictly worse
// entry (or an empty slot) yields its place.
module rank_locator #(
    parameter int TIME_W = 22,
    parameter int DEPTH  = 3,
    parameter int RANK_W = 2
) (
    input  logic [DEPTH-1:0][TIME_W-1:0] entries,
    input  logic [DEPTH-1:0]             valid,
    input  logic [TIME_W-1:0]            new_time,
    input  logic                         larger_wins,
    output logic [RANK_W-1:0]            pos,
    output logic                         found
);

    // Priority search from the worst rank upwards so the best qualifying rank wins.
    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i] ||
                (larger_wins ? (new_time > entries[i]) : (new_time < entries[i]))) begin
                pos   = RANK_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ranked_time_board.sv
// ranked_time_board: two ranked lists (fast/slow) of finished times with a
// three-state insert FSM and a registered read port.
// Optional build macro RANKED_TIME_BOARD_STRETCH_EN stretches rank_hit and
// rank_miss to 2**16 cycles for buzzer drive.
module ranked_time_board
    import ranked_time_pkg::*;
#(
    parameter int TIME_W = 22,
    parameter int DEPTH  = 3,
    parameter int RANK_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TIME_W-1:0] in_time,
    input  logic [1:0]        in_mode,
    input  logic [1:0]        clr_list,
    input  logic              rd_list,
    input  logic [RANK_W-1:0] rd_rank,
    output logic [TIME_W-1:0] rd_time,
    output logic              rd_valid,
    output logic [DEPTH-1:0]  rd_led,
    output logic [DEPTH-1:0]  rank_hit,
    output logic              rank_miss
);

    state_t state;
    state_t state_nx;

    logic [TIME_W-1:0] cap_time;
    logic [1:0]        cap_mode;
    logic              cap_list;
    logic              cap_discard;

    logic [RANK_W-1:0] loc_pos;
    logic              loc_found;
    logic [RANK_W-1:0] pos_q;
    logic              found_q;

    logic [DEPTH-1:0][TIME_W-1:0] tbl [2];
    logic [DEPTH-1:0]             vld [2];

    logic             accept;
    logic             abort;
    logic             write_en;
    logic             miss_ev;
    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] hit_q;
    logic             miss_q;

    assign accept   = in_valid && in_ready;
    // A clear aimed at the list being inserted into cancels the insertion.
    assign abort    = (state != ST_IDLE) && clr_list[cap_list];
    assign write_en = (state == ST_WRITE) && found_q && !cap_discard && !abort;
    assign miss_ev  = (state == ST_WRITE) && !found_q && !cap_discard && !abort;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_SCAN;
            ST_SCAN:  state_nx = abort ? ST_IDLE : ST_WRITE;
            ST_WRITE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: offers are taken only while idle and out of reset.
    always_comb begin
        in_ready = rst_n && (state == ST_IDLE);
    end

    // Capture the offer and, during SCAN, the located insertion rank.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_time    <= in_time;
            cap_mode    <= in_mode;
            cap_list    <= (in_mode == MODE_SLOW) ? LIST_SLOW : LIST_FAST;
            cap_discard <= ((in_mode != MODE_FAST) && (in_mode != MODE_SLOW)) ||
                           (in_time == '0);
        end
        if (state == ST_SCAN) begin
            pos_q   <= loc_pos;
            found_q <= loc_found;
        end
    end

    rank_locator #(
        .TIME_W (TIME_W),
        .DEPTH  (DEPTH),
        .RANK_W (RANK_W)
    ) u_rank_locator (
        .entries     (tbl[cap_list]),
        .valid       (vld[cap_list]),
        .new_time    (cap_time),
        .larger_wins (cap_mode == MODE_SLOW),
        .pos         (loc_pos),
        .found       (loc_found)
    );

    // List storage: shift-and-insert on WRITE, clears override everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                tbl[l] <= '0;
                vld[l] <= '0;
            end
        end else begin
            if (write_en) begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i > int'(pos_q)) begin
                        tbl[cap_list][i] <= tbl[cap_list][i-1];
                        vld[cap_list][i] <= vld[cap_list][i-1];
                    end
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(pos_q)) begin
                        tbl[cap_list][i] <= cap_time;
                        vld[cap_list][i] <= 1'b1;
                    end
                end
            end
            for (int l = 0; l < 2; l++) begin
                if (clr_list[l]) begin
                    tbl[l] <= '0;
                    vld[l] <= '0;
                end
            end
        end
    end

    // One-hot image of the landing rank.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = (i == int'(pos_q));
        end
    end

`ifdef RANKED_TIME_BOARD_STRETCH_EN
    logic [15:0] stretch_cnt;

    // Event pulses held for 2**16 cycles, restarted by each new event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q       <= '0;
            miss_q      <= 1'b0;
            stretch_cnt <= '0;
        end else if (write_en || miss_ev) begin
            hit_q       <= write_en ? hit_vec : '0;
            miss_q      <= miss_ev;
            stretch_cnt <= '1;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - 16'd1;
        end else begin
            hit_q  <= '0;
            miss_q <= 1'b0;
        end
    end
`else
    // Event pulses last the single cycle after WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            hit_q  <= write_en ? hit_vec : '0;
            miss_q <= miss_ev;
        end
    end
`endif

    assign rank_hit  = hit_q;
    assign rank_miss = miss_q;

    // Registered read port; out-of-range ranks read as empty with a dark LED bar.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_time  <= '0;
            rd_valid <= 1'b0;
            rd_led   <= '0;
        end else begin
            rd_time  <= '0;
            rd_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(rd_rank)) begin
                    rd_time  <= vld[rd_list][i] ? tbl[rd_list][i] : '0;
                    rd_valid <= vld[rd_list][i];
                end
                rd_led[i] <= (int'(rd_rank) < DEPTH) && (i <= int'(rd_rank));
            end
        end
    end

endmodule

// File: tb/tb_ranked_time_board.sv
// Directed bench for ranked_time_board (DEPTH=3, default build).
module tb_ranked_time_board;

    localparam int TIME_W = 22;
    localparam int DEPTH  = 3;
    localparam int RANK_W = 2;
    localparam logic [1:0] M_FAST = 2'b10;
    localparam logic [1:0] M_SLOW = 2'b01;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TIME_W-1:0] in_time = '0;
    logic [1:0]        in_mode = 2'b00;
    logic [1:0]        clr_list = 2'b00;
    logic              rd_list = 1'b0;
    logic [RANK_W-1:0] rd_rank = '0;
    logic [TIME_W-1:0] rd_time;
    logic              rd_valid;
    logic [DEPTH-1:0]  rd_led;
    logic [DEPTH-1:0]  rank_hit;
    logic              rank_miss;

    int checks = 0;
    int failures = 0;

    // {rank_hit, rank_miss}
    logic [3:0] exp_q[$];

    ranked_time_board #(.TIME_W(TIME_W), .DEPTH(DEPTH), .RANK_W(RANK_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_time   (in_time),
        .in_mode   (in_mode),
        .clr_list  (clr_list),
        .rd_list   (rd_list),
        .rd_rank   (rd_rank),
        .rd_time   (rd_time),
        .rd_valid  (rd_valid),
        .rd_led    (rd_led),
        .rank_hit  (rank_hit),
        .rank_miss (rank_miss)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout in_ready=%b required=1", in_ready);
        end
    endtask

    // Drive one offer and return the pulse seen on the cycle after WRITE.
    task automatic offer(input logic [TIME_W-1:0] t, input logic [1:0] m, output logic [3:0] obs);
        wait_ready();
        in_valid = 1'b1;
        in_time  = t;
        in_mode  = m;
        step();
        in_valid = 1'b0;
        step();
        step();
        obs = {rank_hit, rank_miss};
    endtask

    task automatic rd(input logic lst, input logic [RANK_W-1:0] rank,
                      output logic [TIME_W-1:0] t, output logic v, output logic [DEPTH-1:0] led);
        rd_list = lst;
        rd_rank = rank;
        step();
        t   = rd_time;
        v   = rd_valid;
        led = rd_led;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (rd_time !== '0) begin failures++; $display("FAIL reset_rd_time got=%0d exp=0", rd_time); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_led !== 3'b000) begin failures++; $display("FAIL reset_rd_led got=%b exp=000", rd_led); end
        checks++; if (rank_hit !== 3'b000) begin failures++; $display("FAIL reset_rank_hit got=%b exp=000", rank_hit); end
        checks++; if (rank_miss !== 1'b0) begin failures++; $display("FAIL reset_rank_miss got=%b exp=0", rank_miss); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        logic [3:0] obs, e;
        logic [TIME_W-1:0] t; logic v; logic [DEPTH-1:0] led;
        exp_q.push_back({3'b001, 1'b0});
        offer(22'd500, M_FAST, obs);
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL single_pulse got=%b exp=%b", obs, e); end
        step();
        checks++; if (rank_hit !== 3'b000) begin failures++; $display("FAIL single_pulse_width got=%b exp=000", rank_hit); end
        rd(1'b0, 2'd0, t, v, led);
        checks++; if (t !== 22'd500) begin failures++; $display("FAIL single_rd_time got=%0d exp=500", t); end
        checks++; if (v !== 1'b1) begin failures++; $display("FAIL single_rd_valid got=%b exp=1", v); end
        checks++; if (led !== 3'b001) begin failures++; $display("FAIL single_rd_led got=%b exp=001", led); end
    endtask

    task automatic test_fast_sort();
        logic [TIME_W-1:0] ins [3] = '{22'd500, 22'd300, 22'd400};
        logic [3:0] pexp [3] = '{4'b0010, 4'b0010, 4'b0100};
        logic [TIME_W-1:0] rexp [3] = '{22'd300, 22'd400, 22'd500};
        logic [DEPTH-1:0] lexp [3] = '{3'b001, 3'b011, 3'b111};
        logic [3:0] obs, e;
        logic [TIME_W-1:0] t; logic v; logic [DEPTH-1:0] led;
        clr_list = 2'b01;
        step();
        clr_list = 2'b00;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pexp[i]);
            offer(ins[i], M_FAST, obs);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin failures++; $display("FAIL fast_sort_pulse%0d got=%b exp=%b", i, obs, e); end
        end
        for (int i = 0; i < 3; i++) begin
            rd(1'b0, RANK_W'(i), t, v, led);
            checks++; if (t !== rexp[i] || v !== 1'b1 || led !== lexp[i]) begin
                failures++; $display("FAIL fast_sort_rd%0d got=%0d/%b/%b exp=%0d/1/%b", i, t, v, led, rexp[i], lexp[i]);
            end
        end
    endtask

    task automatic test_full();
        logic [TIME_W-1:0] r1 [3] = '{22'd300, 22'd400, 22'd500};
        logic [TIME_W-1:0] r2 [3] = '{22'd300, 22'd400, 22'd400};
        logic [3:0] obs, e;
        logic [TIME_W-1:0] t; logic v; logic [DEPTH-1:0] led;
        exp_q.push_back({3'b000, 1'b1});
        offer(22'd600, M_FAST, obs);
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL full_miss got=%b exp=%b", obs, e); end
        for (int i = 0; i < 3; i++) begin
            rd(1'b0, RANK_W'(i), t, v, led);
            checks++; if (t !== r1[i] || v !== 1'b1) begin failures++; $display("FAIL full_unchanged%0d got=%0d/%b exp=%0d/1", i, t, v, r1[i]); end
        end
        exp_q.push_back({3'b100, 1'b0});
        offer(22'd400, M_FAST, obs);
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL full_tie_hit got=%b exp=%b", obs, e); end
        for (int i = 0; i < 3; i++) begin
            rd(1'b0, RANK_W'(i), t, v, led);
            checks++; if (t !== r2[i] || v !== 1'b1) begin failures++; $display("FAIL full_tie_rd%0d got=%0d/%b exp=%0d/1", i, t, v, r2[i]); end
        end
    endtask

    task automatic test_slow();
        logic [TIME_W-1:0] ins [3] = '{22'd10, 22'd90, 22'd50};
        logic [3:0] pexp [3] = '{4'b0010, 4'b0010, 4'b0100};
        logic [TIME_W-1:0] rexp [3] = '{22'd90, 22'd50, 22'd10};
        logic [3:0] obs, e;
        logic [TIME_W-1:0] t; logic v; logic [DEPTH-1:0] led;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pexp[i]);
            offer(ins[i], M_SLOW, obs);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin failures++; $display("FAIL slow_pulse%0d got=%b exp=%b", i, obs, e); end
        end
        for (int i = 0; i < 3; i++) begin
            rd(1'b1, RANK_W'(i), t, v, led);
            checks++; if (t !== rexp[i] || v !== 1'b1) begin failures++; $display("FAIL slow_rd%0d got=%0d/%b exp=%0d/1", i, t, v, rexp[i]); end
        end
        rd(1'b1, 2'd3, t, v, led);
        checks++; if (t !== '0 || v !== 1'b0 || led !== 3'b000) begin
            failures++; $display("FAIL slow_rd_oob got=%0d/%b/%b exp=0/0/000", t, v, led);
        end
    endtask

    task automatic test_clear_abort();
        logic [3:0] obs, e;
        logic [TIME_W-1:0] t; logic v; logic [DEPTH-1:0] led;
        logic seen;
        wait_ready();
        in_valid = 1'b1; in_time = 22'd70; in_mode = M_SLOW;
        step();
        in_valid = 1'b0;
        clr_list = 2'b10;
        step();
        clr_list = 2'b00;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rank_hit !== 3'b000 || rank_miss !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_pulse got=%b exp=0", seen); end
        for (int i = 0; i < 3; i++) begin
            rd(1'b1, RANK_W'(i), t, v, led);
            checks++; if (t !== '0 || v !== 1'b0) begin failures++; $display("FAIL abort_cleared%0d got=%0d/%b exp=0/0", i, t, v); end
        end
        checks++; if (led !== 3'b111) begin failures++; $display("FAIL invalid_entry_led got=%b exp=111", led); end
        // Clearing the other list must not disturb a fast insertion.
        wait_ready();
        in_valid = 1'b1; in_time = 22'd100; in_mode = M_FAST;
        step();
        in_valid = 1'b0;
        clr_list = 2'b10;
        step();
        clr_list = 2'b00;
        step();
        obs = {rank_hit, rank_miss};
        exp_q.push_back({3'b001, 1'b0});
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL other_clear_hit got=%b exp=%b", obs, e); end
        rd(1'b0, 2'd0, t, v, led);
        checks++; if (t !== 22'd100 || v !== 1'b1) begin failures++; $display("FAIL other_clear_rd got=%0d/%b exp=100/1", t, v); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, e;
        logic [TIME_W-1:0] t; logic v; logic [DEPTH-1:0] led;
        int accepts, first, second;
        logic seen;
        wait_ready();
        accepts = 0; first = -1; second = -1; seen = 1'b0;
        in_valid = 1'b1; in_time = 22'd55; in_mode = 2'b11;
        for (int j = 0; j < 12; j++) begin
            if (in_ready === 1'b1) begin
                if (first < 0) first = j;
                else if (second < 0) second = j;
                accepts++;
            end
            if (rank_hit !== 3'b000 || rank_miss !== 1'b0) seen = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++; if (accepts !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", accepts); end
        checks++; if (second - first !== 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", second - first); end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL b2b_no_pulse got=%b exp=0", seen); end
        exp_q.push_back(4'b0000);
        offer(22'd0, M_FAST, obs);
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL zero_time_pulse got=%b exp=%b", obs, e); end
        rd(1'b0, 2'd2, t, v, led);
        checks++; if (t !== 22'd400 || v !== 1'b1) begin failures++; $display("FAIL discard_unchanged got=%0d/%b exp=400/1", t, v); end
        // Reset in the middle of an insertion.
        wait_ready();
        in_valid = 1'b1; in_time = 22'd50; in_mode = M_FAST;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        checks++; if ({in_ready, rd_time, rd_valid, rd_led, rank_hit, rank_miss} !== '0) begin
            failures++; $display("FAIL midreset_outputs got=%b/%0d/%b/%b/%b/%b exp=all0",
                                 in_ready, rd_time, rd_valid, rd_led, rank_hit, rank_miss);
        end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rank_hit !== 3'b000 || rank_miss !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_pulse got=%b exp=0", seen); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", in_ready); end
        rd(1'b0, 2'd0, t, v, led);
        checks++; if (t !== '0 || v !== 1'b0) begin failures++; $display("FAIL midreset_cleared got=%0d/%b exp=0/0", t, v); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fast_sort();
        test_full();
        test_slow();
        test_clear_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ranked_time_board.md
RANKED_TIME_BOARD -- requirements
Module: ranked_time_board

Interface
REQ-001 Parameter TIME_W, default 22, meaning width of every stored time value.
REQ-002 Parameter DEPTH, default 3, meaning number of ranked entries per list, legal range 2..16.
REQ-003 Parameter RANK_W, default $clog2(DEPTH) (min 1), meaning width of the rank index.
REQ-004 clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  meaning the reset, synchronous and active-low.
REQ-006 in_valid  in  1  meaning a new finished time is offered.
REQ-007 in_ready  out  1  meaning the block accepts an offer this cycle.
REQ-008 in_time  in  TIME_W  meaning the offered time.
REQ-009 in_mode  in  2  meaning the target list: 2'b10 fast (smaller wins), 2'b01 slow (larger wins).
REQ-010 clr_list  in  2  meaning a one-cycle clear pulse: bit0 clears fast, bit1 clears slow.
REQ-011 rd_list  in  1  meaning the read list select: 0 fast, 1 slow.
REQ-012 rd_rank  in  RANK_W  meaning the read rank index, 0 is best.
REQ-013 rd_time  out  TIME_W  meaning the selected entry's time.
REQ-014 rd_valid  out  1  meaning the selected entry holds a real time.
REQ-015 rd_led  out  DEPTH  meaning a thermometer code of rank+1 ones, LSB first.
REQ-016 rank_hit  out  DEPTH  meaning a one-cycle one-hot pulse at the rank where the last time landed.
REQ-017 rank_miss  out  1  meaning a one-cycle pulse when the last accepted time did not qualify.

Function
REQ-018 An offer is accepted only in a cycle where in_valid and in_ready are both 1; in_time and in_mode are captured in that cycle.
REQ-019 The FSM has three states:
  - IDLE: in_ready=1; on accept go to SCAN.
  - SCAN: compare the captured time against all DEPTH entries in parallel, register the insertion position, go to WRITE.
  - WRITE: shift entries pos..DEPTH-2 down one rank, write the time at pos, set its valid bit, go to IDLE.
REQ-020 in_ready is 0 in SCAN and WRITE; the accept-to-accept minimum is 3 cycles.
REQ-021 Insertion position is the first rank that is invalid or strictly worse than the new time; ties place the new time after existing equal entries.
REQ-022 If no position exists (list full and the new time is not better than every entry it must beat), the table is unchanged and rank_miss pulses.
REQ-023 rank_hit[pos] or rank_miss is asserted for exactly the one cycle following WRITE.
REQ-024 An offer with in_mode 2'b00 or 2'b11, or with in_time==0, is accepted and discarded, passes through SCAN and WRITE with no table change, and pulses neither rank_hit nor rank_miss.
REQ-025 Each list keeps its own DEPTH valid bits; invalid entries never compare as better than a real time.
REQ-026 The read port has 1-cycle registered latency from rd_list/rd_rank to rd_time, rd_valid and rd_led.
REQ-027 When rd_rank>=DEPTH or the entry is invalid, the read port gives rd_time=0 and rd_valid=0; rd_led is all-zero only when rd_rank>=DEPTH.
REQ-028 clr_list clears the selected valid bits and entry values to 0 in the following cycle.
REQ-029 When clr_list targets the list of an in-flight insertion in SCAN or WRITE, the insertion is aborted: return to IDLE, no write, no pulse.
REQ-030 When clr_list targets the other list, the in-flight insertion completes normally.
REQ-031 A read of an entry written in WRITE returns the new value no earlier than the cycle after WRITE plus read latency.

Reset
REQ-032 While rst_n=0 at a clock edge, the block resets to: FSM=IDLE, all entries=0, all valid bits=0, in_ready=1 after release, rd_time=0, rd_valid=0, rd_led=0, rank_hit=0, rank_miss=0.
REQ-033 Reset asserted mid-insertion discards the insertion without a pulse.

Configuration
REQ-034 With macro RANKED_TIME_BOARD_STRETCH_EN defined, rank_hit and rank_miss are held for 2**16 cycles after each event, restarting on a new event, for audible buzzer drive.
REQ-035 Without RANKED_TIME_BOARD_STRETCH_EN, the pulses last one cycle and no stretch counter exists.

Structure
REQ-036 Package ranked_time_pkg holds the FSM state enum, the mode constants MODE_FAST=2'b10 and MODE_SLOW=2'b01, and the list index constants.
REQ-037 Sub-module rank_locator computes the insertion position for one list and mode; it is instantiated once and muxed by the captured mode.

Verification
REQ-038 The bench covers these directed scenarios (DEPTH=3):
  - After reset, offer fast 500 -> rank_hit=3'b001 on the cycle after WRITE; read fast rank0 gives rd_time=500, rd_valid=1, rd_led=3'b001.
  - Fast inserts 500, 300, 400 -> fast list reads 300, 400, 500; the pulses are hit ranks 0, 0, 1.
  - Full fast list {300,400,500}, offer 600 -> rank_miss=1 and the list is unchanged; offer 400 -> rank_hit=3'b100 and the list becomes 300, 400, 400.
  - Slow inserts 10, 90, 50 -> slow list reads 90, 50, 10; read rd_rank=3 gives rd_valid=0, rd_led=0.
  - Offer slow 70, then clr_list=2'b10 during SCAN -> no pulse; slow list all invalid; in_ready=1 next cycle.
  - in_valid held high with in_mode=2'b11 -> accepts every 3 cycles, no pulses; assert rst_n=0 mid-insertion -> all outputs 0.
